reg_bank_mp: RTL and testbench

Parametrised multi-port register bank, successor to the single-write ARM register bank. It holds NREG general registers of DW bits and a 4-bit NZCV flag register. It provides NUM_RD registered read ports, two prioritised write ports plus a PC-update port, and a per-register pending-load scoreboard. It sits between decode/writeback and the ALU/shifter operand buses, and replaces the negedge-read scheme with posedge reads and optional write-through bypass.

---
 rtl/reg_bank_mp.sv | 102 ++++++++++
 tb/tb_reg_bank_mp.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_mp.sv
// Multi-port register bank: NREG x DW registers, NZCV flags, prioritised writes,
// registered read ports with optional write-through bypass, and a pending-load scoreboard.
module reg_bank_mp #(
  parameter int unsigned DW     = 32,
  parameter int unsigned NREG   = 16,
  parameter int unsigned NUM_RD = 3,
  parameter int unsigned PC_IDX = 15,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_RD-1:0]    rd_en,
  input  logic [NUM_RD*AW-1:0] rd_sel,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_hazard,
  input  logic                 wr0_en,
  input  logic [AW-1:0]        wr0_sel,
  input  logic [DW-1:0]        wr0_data,
  input  logic                 wr1_en,
  input  logic [AW-1:0]        wr1_sel,
  input  logic [DW-1:0]        wr1_data,
  input  logic                 pc_wr_en,
  input  logic [DW-1:0]        pc_wr_data,
  input  logic                 lock_en,
  input  logic [AW-1:0]        lock_sel,
  input  logic [3:0]           flags_wr_mask,
  input  logic [3:0]           flags_wr_data,
  output logic [3:0]           flags,
  output logic [DW-1:0]        pc_data,
  output logic [NREG-1:0]      pending
);

  logic [NREG-1:0][DW-1:0]   regs_q;
  logic [NREG-1:0][DW-1:0]   regs_nxt;
  logic [NREG-1:0]           pend_nxt;
  logic [3:0]                flags_nxt;
  logic [NUM_RD-1:0][DW-1:0] rd_val;
  logic [NUM_RD-1:0]         rd_hz;
  logic [DW-1:0]             pc_val;

  // Per-register write resolution (wr0 > wr1 > pc_wr) and scoreboard update (set beats clear).
  // Selects at or above NREG match no register, so they are dropped naturally.
  always_comb begin
    regs_nxt = regs_q;
    pend_nxt = pending;
    for (int r = 0; r < int'(NREG); r++) begin
      if (wr0_en && (wr0_sel == AW'(r))) begin
        regs_nxt[r] = wr0_data;
      end else if (wr1_en && (wr1_sel == AW'(r))) begin
        regs_nxt[r] = wr1_data;
      end else if (pc_wr_en && (r == int'(PC_IDX))) begin
        regs_nxt[r] = pc_wr_data;
      end
      if (wr1_en && (wr1_sel == AW'(r))) begin
        pend_nxt[r] = 1'b0;
      end
      if (lock_en && (lock_sel == AW'(r))) begin
        pend_nxt[r] = 1'b1;
      end
    end
    flags_nxt = (flags & ~flags_wr_mask) | (flags_wr_data & flags_wr_mask);
  end

  // Read mux: post-update view when bypassing, pre-update view otherwise
  always_comb begin
    rd_val = '0;
    rd_hz  = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      for (int r = 0; r < int'(NREG); r++) begin
        if (rd_sel[i*AW +: AW] == AW'(r)) begin
          rd_val[i] = (BYPASS != 0) ? regs_nxt[r] : regs_q[r];
          rd_hz[i]  = (BYPASS != 0) ? pend_nxt[r] : pending[r];
        end
      end
    end
    pc_val = (BYPASS != 0) ? regs_nxt[PC_IDX] : regs_q[PC_IDX];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      regs_q    <= '0;
      pending   <= '0;
      flags     <= '0;
      pc_data   <= '0;
      rd_data   <= '0;
      rd_hazard <= '0;
    end else begin
      regs_q  <= regs_nxt;
      pending <= pend_nxt;
      flags   <= flags_nxt;
      pc_data <= pc_val;
      for (int i = 0; i < int'(NUM_RD); i++) begin
        if (rd_en[i]) begin
          rd_data[i*DW +: DW] <= rd_val[i];
          rd_hazard[i]        <= rd_hz[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// Directed bench for reg_bank_mp: bypass and non-bypass instances plus a
// non-power-of-2 instance sharing one stimulus stream.
module tb_reg_bank_mp;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  rd_en;
  logic [11:0] rd_sel;
  logic        wr0_en, wr1_en, pc_wr_en, lock_en;
  logic [3:0]  wr0_sel, wr1_sel, lock_sel;
  logic [31:0] wr0_data, wr1_data, pc_wr_data;
  logic [3:0]  flags_wr_mask, flags_wr_data;

  logic [95:0] rd_data_a, rd_data_b, rd_data_c;
  logic [2:0]  rd_hazard_a, rd_hazard_b, rd_hazard_c;
  logic [3:0]  flags_a, flags_b, flags_c;
  logic [31:0] pc_a, pc_b, pc_c;
  logic [15:0] pend_a, pend_b;
  logic [11:0] pend_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_bank_mp #(.BYPASS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_data(rd_data_a), .rd_hazard(rd_hazard_a),
    .wr0_en(wr0_en), .wr0_sel(wr0_sel), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_sel(wr1_sel), .wr1_data(wr1_data),
    .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data),
    .lock_en(lock_en), .lock_sel(lock_sel),
    .flags_wr_mask(flags_wr_mask), .flags_wr_data(flags_wr_data),
    .flags(flags_a), .pc_data(pc_a), .pending(pend_a));

  reg_bank_mp #(.BYPASS(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_data(rd_data_b), .rd_hazard(rd_hazard_b),
    .wr0_en(wr0_en), .wr0_sel(wr0_sel), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_sel(wr1_sel), .wr1_data(wr1_data),
    .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data),
    .lock_en(lock_en), .lock_sel(lock_sel),
    .flags_wr_mask(flags_wr_mask), .flags_wr_data(flags_wr_data),
    .flags(flags_b), .pc_data(pc_b), .pending(pend_b));

  reg_bank_mp #(.NREG(12), .PC_IDX(11), .BYPASS(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .rd_en(rd_en), .rd_sel(rd_sel),
    .rd_data(rd_data_c), .rd_hazard(rd_hazard_c),
    .wr0_en(wr0_en), .wr0_sel(wr0_sel), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_sel(wr1_sel), .wr1_data(wr1_data),
    .pc_wr_en(pc_wr_en), .pc_wr_data(pc_wr_data),
    .lock_en(lock_en), .lock_sel(lock_sel),
    .flags_wr_mask(flags_wr_mask), .flags_wr_data(flags_wr_data),
    .flags(flags_c), .pc_data(pc_c), .pending(pend_c));

  typedef struct {
    logic        w0e; logic [3:0] w0s; logic [31:0] w0d;
    logic        w1e; logic [3:0] w1s; logic [31:0] w1d;
    logic        pce; logic [31:0] pcd;
    logic        lke; logic [3:0] lks;
    logic [3:0]  fm;  logic [3:0] fd;
    logic        re0; logic [3:0] rs0;
    logic [31:0] e_rd; logic e_hz; logic [31:0] e_pc; logic [3:0] e_fl; logic [15:0] e_pend;
    logic [31:0] e_rdb; logic e_hzb; logic [31:0] e_pcb;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    wr0_en = 0; wr0_sel = 0; wr0_data = 0;
    wr1_en = 0; wr1_sel = 0; wr1_data = 0;
    pc_wr_en = 0; pc_wr_data = 0;
    lock_en = 0; lock_sel = 0;
    flags_wr_mask = 0; flags_wr_data = 0;
    rd_en = 0; rd_sel = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          w0e w0s w0d           w1e w1s w1d    pce pcd     lke lks fm       fd       re0 rs0   e_rd          e_hz e_pc    e_fl     e_pend    e_rdb   e_hzb e_pcb
    vecs[0]  = '{1, 5,  32'h12345678, 0, 0,  0,      0, 0,       0, 0,  4'b0000, 4'b0000, 1, 5,  32'h12345678, 0, 32'h0,   4'b0000, 16'h0000, 32'h0,  0, 32'h0};
    vecs[1]  = '{1, 15, 32'h100,      1, 15, 32'h200, 1, 32'h300, 0, 0, 4'b0000, 4'b0000, 1, 15, 32'h100,      0, 32'h100, 4'b0000, 16'h0000, 32'h0,  0, 32'h0};
    vecs[2]  = '{0, 0,  0,            0, 0,  0,      1, 32'h304, 0, 0,  4'b0000, 4'b0000, 1, 15, 32'h304,      0, 32'h304, 4'b0000, 16'h0000, 32'h100, 0, 32'h100};
    vecs[3]  = '{1, 1,  32'hA,        1, 2,  32'hB,  1, 32'h40,  0, 0,  4'b0000, 4'b0000, 1, 1,  32'hA,        0, 32'h40,  4'b0000, 16'h0000, 32'h0,  0, 32'h304};
    vecs[4]  = '{0, 0,  0,            0, 0,  0,      0, 0,       0, 0,  4'b0000, 4'b0000, 1, 2,  32'hB,        0, 32'h40,  4'b0000, 16'h0000, 32'hB,  0, 32'h40};
    vecs[5]  = '{0, 0,  0,            0, 0,  0,      0, 0,       1, 7,  4'b0000, 4'b0000, 1, 7,  32'h0,        1, 32'h40,  4'b0000, 16'h0080, 32'h0,  0, 32'h40};
    vecs[6]  = '{0, 0,  0,            1, 7,  32'h33, 0, 0,       1, 7,  4'b0000, 4'b0000, 1, 7,  32'h33,       1, 32'h40,  4'b0000, 16'h0080, 32'h0,  1, 32'h40};
    vecs[7]  = '{0, 0,  0,            1, 7,  32'h55, 0, 0,       0, 0,  4'b0000, 4'b0000, 1, 7,  32'h55,       0, 32'h40,  4'b0000, 16'h0000, 32'h33, 1, 32'h40};
    vecs[8]  = '{0, 0,  0,            0, 0,  0,      0, 0,       0, 0,  4'b1010, 4'b1111, 0, 7,  32'h55,       0, 32'h40,  4'b1010, 16'h0000, 32'h33, 1, 32'h40};
    vecs[9]  = '{1, 1,  32'h77,       0, 0,  0,      0, 0,       0, 0,  4'b0001, 4'b0001, 0, 1,  32'h55,       0, 32'h40,  4'b1011, 16'h0000, 32'h33, 1, 32'h40};
    vecs[10] = '{0, 0,  0,            0, 0,  0,      0, 0,       0, 0,  4'b0000, 4'b0000, 1, 1,  32'h77,       0, 32'h40,  4'b1011, 16'h0000, 32'h77, 0, 32'h40};
    vecs[11] = '{1, 9,  32'h11,       0, 0,  0,      0, 0,       1, 9,  4'b0000, 4'b0000, 1, 9,  32'h11,       1, 32'h40,  4'b1011, 16'h0200, 32'h0,  0, 32'h40};
    vecs[12] = '{1, 9,  32'h22,       1, 9,  32'h33, 0, 0,       0, 0,  4'b0000, 4'b0000, 1, 9,  32'h22,       0, 32'h40,  4'b1011, 16'h0000, 32'h11, 1, 32'h40};
    vecs[13] = '{0, 0,  0,            1, 3,  32'h5,  1, 32'h500, 0, 0,  4'b0000, 4'b0000, 1, 3,  32'h5,        0, 32'h500, 4'b1011, 16'h0000, 32'h0,  0, 32'h40};

    // Power-up reset
    idle();
    reset_n = 1'b0;
    step();
    step();
    chk("init_rd_a", rd_data_a[31:0], 32'h0);
    chk("init_pc_a", pc_a, 32'h0);
    chk("init_flags_a", 32'(flags_a), 32'h0);
    chk("init_pend_a", 32'(pend_a), 32'h0);
    chk("init_rd_b", rd_data_b[31:0], 32'h0);

    // Load R3, lock R4, set flags, then reset with writes in flight
    reset_n = 1'b1;
    wr0_en = 1; wr0_sel = 3; wr0_data = 32'hDEADBEEF;
    lock_en = 1; lock_sel = 4;
    flags_wr_mask = 4'hF; flags_wr_data = 4'hF;
    rd_en = 3'b001; rd_sel = {4'd0, 4'd0, 4'd3};
    step();
    chk("pre_rst_rd_a", rd_data_a[31:0], 32'hDEADBEEF);
    chk("pre_rst_pend_a", 32'(pend_a), 32'h0010);
    chk("pre_rst_flags_a", 32'(flags_a), 32'hF);
    reset_n = 1'b0;
    wr0_sel = 6; wr0_data = 32'h1234;
    lock_sel = 8;
    step();
    chk("rst_rd_a", rd_data_a[31:0], 32'h0);
    chk("rst_pc_a", pc_a, 32'h0);
    chk("rst_flags_a", 32'(flags_a), 32'h0);
    chk("rst_pend_a", 32'(pend_a), 32'h0);
    chk("rst_hz_a", 32'(rd_hazard_a), 32'h0);
    reset_n = 1'b1;
    idle();
    rd_en = 3'b011; rd_sel = {4'd0, 4'd6, 4'd3};
    step();
    chk("post_rst_r3_a", rd_data_a[31:0], 32'h0);
    chk("post_rst_r6_a", rd_data_a[63:32], 32'h0);
    chk("post_rst_r3_b", rd_data_b[31:0], 32'h0);
    chk("post_rst_pend_a", 32'(pend_a), 32'h0);

    // Table-driven single-port sequence
    for (int v = 0; v < 14; v++) begin
      idle();
      wr0_en = vecs[v].w0e; wr0_sel = vecs[v].w0s; wr0_data = vecs[v].w0d;
      wr1_en = vecs[v].w1e; wr1_sel = vecs[v].w1s; wr1_data = vecs[v].w1d;
      pc_wr_en = vecs[v].pce; pc_wr_data = vecs[v].pcd;
      lock_en = vecs[v].lke; lock_sel = vecs[v].lks;
      flags_wr_mask = vecs[v].fm; flags_wr_data = vecs[v].fd;
      rd_en = {2'b00, vecs[v].re0}; rd_sel = {8'h00, vecs[v].rs0};
      step();
      chk($sformatf("v%0d_rd_a", v), rd_data_a[31:0], vecs[v].e_rd);
      chk($sformatf("v%0d_hz_a", v), 32'(rd_hazard_a[0]), 32'(vecs[v].e_hz));
      chk($sformatf("v%0d_pc_a", v), pc_a, vecs[v].e_pc);
      chk($sformatf("v%0d_flags_a", v), 32'(flags_a), 32'(vecs[v].e_fl));
      chk($sformatf("v%0d_pend_a", v), 32'(pend_a), 32'(vecs[v].e_pend));
      chk($sformatf("v%0d_rd_b", v), rd_data_b[31:0], vecs[v].e_rdb);
      chk($sformatf("v%0d_hz_b", v), 32'(rd_hazard_b[0]), 32'(vecs[v].e_hzb));
      chk($sformatf("v%0d_pc_b", v), pc_b, vecs[v].e_pcb);
    end

    // Three ports in parallel with no writes
    idle();
    rd_en = 3'b111; rd_sel = {4'd2, 4'd1, 4'd5};
    step();
    chk("mp_p0_a", rd_data_a[31:0], 32'h12345678);
    chk("mp_p1_a", rd_data_a[63:32], 32'h77);
    chk("mp_p2_a", rd_data_a[95:64], 32'hB);
    chk("mp_p2_b", rd_data_b[95:64], 32'hB);

    // Out-of-range selects on the 12-entry instance
    idle();
    wr0_en = 1; wr0_sel = 13; wr0_data = 32'hFFFF;
    wr1_en = 1; wr1_sel = 12; wr1_data = 32'hEEEE;
    lock_en = 1; lock_sel = 13;
    rd_en = 3'b011; rd_sel = {4'd0, 4'd5, 4'd13};
    step();
    chk("oor_rd_c", rd_data_c[31:0], 32'h0);
    chk("oor_hz_c", 32'(rd_hazard_c[0]), 32'h0);
    chk("oor_pend_c", 32'(pend_c), 32'h0);
    chk("oor_inrange_c", rd_data_c[63:32], 32'h12345678);
    idle();
    rd_en = 3'b001; rd_sel = {4'd0, 4'd0, 4'd12};
    step();
    chk("oor_rd12_c", rd_data_c[31:0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
